// File: rtl/ahb_svt_arbiter.sv
// Registered AHB-2 bus arbiter: round-robin over masters 1..NUM_MST-1 with master 0
// as the default owner, fixed-length burst protection, locked transfers and SPLIT masking.
module ahb_svt_arbiter #(
    parameter int unsigned NUM_MST   = 2,
    parameter int unsigned HMASTER_W = 4
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [NUM_MST-1:0]   hbusreq,
    input  logic [NUM_MST-1:0]   hlock,
    input  logic [1:0]           htrans,
    input  logic [2:0]           hburst,
    input  logic                 hready,
    input  logic [1:0]           hresp,
    input  logic [15:0]          hsplit,
    output logic [NUM_MST-1:0]   hgrant,
    output logic [HMASTER_W-1:0] hmaster,
    output logic                 hmastlock
);

    localparam int unsigned IdxW = $clog2(NUM_MST);

    localparam logic [1:0] TransBusy   = 2'd1;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;
    localparam logic [1:0] RespRetry   = 2'd2;
    localparam logic [1:0] RespSplit   = 2'd3;

    localparam logic [NUM_MST-1:0] GrantDefault = {{(NUM_MST-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StFree,
        StBurst,
        StLocked
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           beats_left_q, beats_left_d;
    logic [IdxW-1:0]      last_owner_q, last_owner_d;
    logic [NUM_MST-1:0]   split_mask_q, split_mask_d;
    logic [NUM_MST-1:0]   grant_q, grant_d;
    logic [HMASTER_W-1:0] hmaster_q, hmaster_d;
    logic                 hmastlock_q, hmastlock_d;

    logic                 abort;
    logic                 arb;
    logic                 fixed_burst;
    logic [3:0]           burst_len;
    logic [NUM_MST-1:0]   split_set;
    logic [NUM_MST-1:0]   cand;
    logic [IdxW-1:0]      winner;
    logic [IdxW-1:0]      grant_idx;
    logic [IdxW-1:0]      owner_idx;

    // Round-robin pick among candidates, starting just after the last owner; 0 if none.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NUM_MST-1:0] c,
                                                input logic [IdxW-1:0]    last);
        logic [IdxW-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_MST - 1; k++) begin
            idx = ((32'(last) + k) % (NUM_MST - 1)) + 1;
            if (!found && c[idx[IdxW-1:0]]) begin
                pick  = idx[IdxW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // One-hot to index; the grant vector is always exactly one-hot.
    function automatic logic [IdxW-1:0] oh2idx(input logic [NUM_MST-1:0] oh);
        logic [IdxW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_MST; i++) begin
            if (oh[i]) begin
                r = i[IdxW-1:0];
            end
        end
        return r;
    endfunction

    // Split mask update, candidate set and round-robin winner.
    always_comb begin
        // First cycle of a two-cycle RETRY/SPLIT response is the one with hready low.
        abort     = !hready && ((hresp == RespRetry) || (hresp == RespSplit));
        owner_idx = hmaster_q[IdxW-1:0];
        grant_idx = oh2idx(grant_q);

        split_set = '0;
        if (abort && (hresp == RespSplit) && (owner_idx != '0)) begin
            split_set[owner_idx] = 1'b1;
        end
        // Release wins over a same-cycle set of the same bit.
        split_mask_d    = (split_mask_q | split_set) & ~hsplit[NUM_MST-1:0];
        split_mask_d[0] = 1'b0;

        cand    = hbusreq & ~split_mask_d;
        cand[0] = 1'b0;
        winner  = rr_pick(cand, last_owner_q);

        fixed_burst = (hburst[2:1] != 2'b00);
        unique case (hburst[2:1])
            2'b01:   burst_len = 4'd3;
            2'b10:   burst_len = 4'd7;
            2'b11:   burst_len = 4'd15;
            default: burst_len = 4'd0;
        endcase
    end

    // Next-state: arbitration points, burst countdown and lock hold.
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        arb          = 1'b0;

        if (abort) begin
            arb = 1'b1;
        end else if (hready) begin
            unique case (state_q)
                StFree: begin
                    if ((htrans == TransNonseq) && fixed_burst) begin
                        // Pin the grant on the master that started the burst.
                        state_d      = StBurst;
                        beats_left_d = burst_len;
                        grant_d      = GrantDefault << owner_idx;
                    end else begin
                        arb = 1'b1;
                    end
                end
                StBurst: begin
                    if (htrans == TransSeq) begin
                        if (beats_left_q <= 4'd1) begin
                            arb = 1'b1;
                        end else begin
                            beats_left_d = beats_left_q - 4'd1;
                        end
                    end
                end
                StLocked: begin
                    if (!hlock[grant_idx] && (htrans != TransSeq) && (htrans != TransBusy)) begin
                        arb = 1'b1;
                    end
                end
                default: begin
                    arb = 1'b1;
                end
            endcase
        end

        if (arb) begin
            grant_d      = GrantDefault << winner;
            last_owner_d = winner;
            beats_left_d = 4'd0;
            state_d      = (winner != '0 && hlock[winner]) ? StLocked : StFree;
        end
    end

    // Address-phase ownership follows the grant only on accepted cycles.
    always_comb begin
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (hready) begin
            hmaster_d   = HMASTER_W'(grant_idx);
            hmastlock_d = hlock[grant_idx];
        end
    end

    // State registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= StFree;
            beats_left_q <= 4'd0;
            last_owner_q <= '0;
            split_mask_q <= '0;
            grant_q      <= GrantDefault;
            hmaster_q    <= '0;
            hmastlock_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            last_owner_q <= last_owner_d;
            split_mask_q <= split_mask_d;
            grant_q      <= grant_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

    logic unused_inputs;
    assign unused_inputs = ^{hsplit, hburst[0]};

endmodule

// File: doc/ahb_svt_arbiter.md
# ahb_svt_arbiter

- Registered AHB-2 bus arbiter for the single-layer AHB testbench interconnect.
- Sits directly upstream of the interconnect's address/data mux.
  - Decides ownership from the masters' `hbusreq`/`hlock` and the bus state.
  - Drives `hgrant_m*`, `hmaster` and `hmastlock` to masters and slaves.
- Handles fixed-length burst protection, locked transfers and SPLIT masking.
- Master 0 is the default (dummy) master.

## Interface
Parameters:
- `NUM_MST`, default 2: number of masters, 2..16; index 0 is the default master.
- `HMASTER_W`, default 4: width of `hmaster`.

Ports:
- `hclk` in 1: bus clock.
- `hresetn` in 1: reset, asynchronous, active-low.
- `hbusreq` in `NUM_MST`: per-master bus request; bit 0 is ignored.
- `hlock` in `NUM_MST`: per-master lock request.
- `htrans` in 2: bus `htrans` (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `hburst` in 3: bus `hburst`.
- `hready` in 1: bus `hready`.
- `hresp` in 2: bus `hresp` (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- `hsplit` in 16: OR of all slaves' `hsplit`; bit i releases master i.
- `hgrant` out `NUM_MST`: one-hot grant.
- `hmaster` out `HMASTER_W`: index of the master owning the current address phase.
- `hmastlock` out 1: current address phase is locked.

## Operation
State machine (`state`):
- FREE: arbitration allowed.
  - Evaluated on every cycle with `hready`=1.
- BURST: fixed-length burst in progress.
  - Entered when `hready`=1, `htrans`=NONSEQ and `hburst` is INCR4/WRAP4, INCR8/WRAP8 or INCR16/WRAP16.
  - Loads `beats_left` = 3, 7 or 15.
  - `beats_left` decrements on each accepted SEQ beat (`hready`=1 and `htrans`=SEQ).
  - BUSY beats do not decrement it.
  - The transition to FREE and the grant re-evaluation both happen when the accepted SEQ takes `beats_left` from 1 to 0.
- LOCKED: entered from FREE or BURST when the winner has `hlock`=1 at the arbitration point.
  - Holds the grant while the owner keeps `hlock`=1.
  - Exits to FREE on the first `hready`=1 cycle with the owner's `hlock`=0 and `htrans`≠SEQ/BUSY.

Winner selection at an arbitration point:
- Candidates are masters i≥1 with `hbusreq[i]`=1 and `split_mask[i]`=0.
- Round-robin: search starts at `(last_owner+1)` over indices 1..`NUM_MST`-1 and wraps.
- No candidate → master 0.

Split mask:
- Set: on the first cycle of a SPLIT response (`hresp`=SPLIT, `hready`=0), set `split_mask[hmaster]`.
  - Master 0 is never masked.
- Clear: `hsplit[i]`=1 clears `split_mask[i]`.
  - Clear has priority over a same-cycle set of the same bit.

Retry/split abort:
- On the first cycle of a RETRY or SPLIT response, the state forces to FREE, including from BURST or LOCKED.
- In that cycle the grant is re-evaluated regardless of `hready`.
- ERROR does not alter state.

Outputs:
- Grant is owned only when `hready`=1.
  - Exception: the RETRY/SPLIT first cycle.
- `hmaster` and `hmastlock` update only when `hready`=1.
  - `hmaster` <= index of the current `hgrant`.
  - `hmastlock` <= `hlock[granted]`.
- `hmaster` is zero-extended.
- Indices ≥ `NUM_MST` never appear.

## Timing
Reset (`hresetn`=0):
- Outputs: `hgrant`=1 (master 0), `hmaster`=0, `hmastlock`=0.
- Internal: `state`=FREE, `split_mask`=0, `beats_left`=0, `last_owner`=0.

Latency:
- Request → grant: `hbusreq` sampled at edge N with `hready`=1 → `hgrant` changes after edge N.
- Grant → ownership: `hmaster` follows `hgrant` on the next `hready`=1 edge.
  - This is 1 cycle minimum after the grant.

Wait states and reset:
- `hready`=0 freezes `hgrant`, `hmaster`, `hmastlock`, `beats_left` and `state`.
  - Only SPLIT/RETRY first-cycle handling and `hsplit` clears still act.
- Reset asserted mid-burst or mid-lock returns to reset values immediately (asynchronous).
- After release, the first edge behaves as FREE.

## Test plan
1. **Idle default:** after reset all `hbusreq`=0.
   - Required: `hgrant`=2'b01 and `hmaster`=0 held for 20 cycles.
2. **Single request:** m1 raises `hbusreq` at cycle 5, `hready`=1.
   - Required: `hgrant`=2'b10 after edge 5, `hmaster`=1 after edge 6.
   - Required: dropping `hbusreq` at cycle 10 returns `hgrant`=2'b01 after edge 10.
3. **INCR4 protection:** `NUM_MST`=3, m1 owns and issues NONSEQ INCR4, with one BUSY and two `hready`=0 cycles inserted; m2 requests on the NONSEQ cycle.
   - Required: `hgrant` stays on m1 until the 3rd SEQ is accepted, then moves to m2.
4. **Lock:** m1 wins with `hlock`=1, m2 requesting, m1 issues 3 NONSEQ singles.
   - Required: `hmastlock`=1 and the grant stays on m1 throughout.
   - Required: `hlock` dropped on an IDLE accepted beat → grant moves to m2 on that edge.
5. **SPLIT:** m1 owns; slave returns SPLIT for 2 cycles (`hready` 0 then 1).
   - Required: the grant moves to master 0 on the first cycle.
   - Required: m1 stays ungranted despite `hbusreq`=1.
   - Required: `hsplit[1]`=1 → m1 re-granted on the next `hready`=1 edge.
6. **Reset mid-burst:** `hresetn` low during INCR8 beat 4.
   - Required: `hgrant`=01, `hmaster`=0 and `hmastlock`=0 with no clock edge.
   - Required: after release, a new m1 request is granted in 1 cycle.
